// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// Each operation runs grant -> EXEC (ALU sample) -> RESP (held until accepted).
module alu_share_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_x,
    input  logic [15:0] req0_y,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_x,
    input  logic [15:0] req1_y,
    input  logic [2:0]  req1_op,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_s,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [15:0] opx_q, opx_d;
    logic [15:0] opy_q, opy_d;
    logic [2:0]  opop_q, opop_d;
    logic        opid_q, opid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        gnt0, gnt1;

    function automatic logic op_illegal(input logic [2:0] op);
        return (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    endfunction

    // Grants are gated by rst_n so no ready can leak out while reset is held.
    always_comb begin
        gnt0 = rst_n && (state_q == ST_IDLE) && req0_valid && (!req1_valid || !ptr_q);
        gnt1 = rst_n && (state_q == ST_IDLE) && req1_valid && (!req0_valid ||  ptr_q);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        opx_d      = opx_q;
        opy_d      = opy_q;
        opop_d     = opop_q;
        opid_d     = opid_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0) begin
                    opx_d   = req0_x;
                    opy_d   = req0_y;
                    opop_d  = req0_op;
                    opid_d  = 1'b0;
                    state_d = ST_EXEC;
                end else if (gnt1) begin
                    opx_d   = req1_x;
                    opy_d   = req1_y;
                    opop_d  = req1_op;
                    opid_d  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_err_d  = op_illegal(opop_q);
                rsp_data_d = op_illegal(opop_q) ? 16'h0000 : alu_s;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                // The requester that was just served drops to lower priority.
                if (rsp_ready) begin
                    ptr_d   = ~opid_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            opx_q      <= 16'h0000;
            opy_q      <= 16'h0000;
            opop_q     <= 3'b000;
            opid_q     <= 1'b0;
            rsp_data_q <= 16'h0000;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            opx_q      <= opx_d;
            opy_q      <= opy_d;
            opop_q     <= opop_d;
            opid_q     <= opid_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign alu_x      = opx_q;
    assign alu_y      = opy_q;
    assign alu_op     = opop_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = opid_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
- REQ-001: The block SHALL have one clock and one reset: the clock is `clk`, and the reset is `rst_n`, which is asynchronous and active-low.
- REQ-002: Port list (name, direction, width, meaning):
  - `clk`, in, 1, rising-edge clock.
  - `rst_n`, in, 1, asynchronous active-low reset.
  - `req0_valid`, in, 1, requester 0 has an operation pending.
  - `req0_ready`, out, 1, requester 0 operation accepted this cycle.
  - `req0_x`, in, 16, requester 0 operand x.
  - `req0_y`, in, 16, requester 0 operand y.
  - `req0_op`, in, 3, requester 0 opcode.
  - `req1_valid`, `req1_ready`, `req1_x`, `req1_y`, `req1_op`: same as above, for requester 1.
  - `alu_x`, out, 16, operand x to the shared ALU.
  - `alu_y`, out, 16, operand y to the shared ALU.
  - `alu_op`, out, 3, opcode to the shared ALU.
  - `alu_s`, in, 16, combinational ALU result.
  - `rsp_valid`, out, 1, response available.
  - `rsp_ready`, in, 1, consumer accepts the response.
  - `rsp_data`, out, 16, result.
  - `rsp_id`, out, 1, requester that owns the response.
  - `rsp_err`, out, 1, opcode was illegal.
  - `busy`, out, 1, FSM not in IDLE.
- REQ-003: Legal opcodes SHALL be:
  - 000 = AND
  - 001 = OR
  - 010 = ADD
  - 110 = SUB
  - 111 = SLT
- REQ-004: Opcodes 011, 100 and 101 SHALL be illegal.

Function
- REQ-005: The FSM SHALL have three states: IDLE, EXEC and RESP.
- REQ-006: IDLE with no `reqN_valid` SHALL remain in IDLE; all `reqN_ready` = 0.
- REQ-007: IDLE with at least one valid requester SHALL grant exactly one requester, combinationally asserting only that requester's `reqN_ready` in the same cycle.
- REQ-008: On a grant, the granted x, y, op and id SHALL be latched into operand registers at the clock edge, and the FSM SHALL move to EXEC.
- REQ-009: Arbitration SHALL be round-robin:
  - The priority pointer resets to requester 0.
  - On both-valid, the pointer's requester wins.
  - On single-valid, that requester wins regardless of the pointer.
- REQ-010: After each completed response handshake, the pointer SHALL be set to the requester that did not own that response.
- REQ-011: `alu_x`, `alu_y` and `alu_op` SHALL always equal the operand registers; no combinational path from `reqN_*` to `alu_*` is allowed.
- REQ-012: In EXEC, `alu_s` SHALL be captured into `rsp_data` at the clock edge, and the FSM SHALL move to RESP (one-cycle ALU latency).
- REQ-013: If the latched op is illegal, `rsp_data` SHALL be captured as 0x0000 and `rsp_err` set to 1; otherwise `rsp_err` = 0.
- REQ-014: In RESP, `rsp_valid` SHALL be 1, and `rsp_data`, `rsp_id` and `rsp_err` SHALL be held stable until `rsp_valid` && `rsp_ready`.
- REQ-015: On the RESP handshake edge, the FSM SHALL return to IDLE with `rsp_valid` = 0.
- REQ-016: No grant SHALL occur in EXEC or RESP; a `reqN_valid` held during those states SHALL stay pending with `reqN_ready` = 0.
- REQ-017: Minimum issue-to-issue spacing SHALL be 3 cycles: grant, EXEC, and RESP with immediate `rsp_ready`.
- REQ-018: `busy` SHALL be 1 exactly in EXEC and RESP.
- REQ-019: A `rsp_ready` asserted outside RESP SHALL have no effect.

Reset
- REQ-020: While `rst_n` = 0, the block SHALL hold:
  - state = IDLE, pointer = 0.
  - operand registers, `alu_x`, `alu_y`, `alu_op` = 0.
  - `rsp_valid`, `rsp_data`, `rsp_id`, `rsp_err`, `busy`, `req0_ready`, `req1_ready` = 0.
- REQ-021: Reset asserted in EXEC or RESP SHALL abandon the operation immediately, with no response issued after release.
- REQ-022: The first grant after reset release SHALL occur no earlier than the first rising edge with `rst_n` = 1.

Verification
- REQ-023: Single ADD: `req0` x=0x0003, y=0x0004, op=010 valid at cycle N → the bench SHALL check:
  - `req0_ready`=1 at N.
  - `alu_op`=010 at N+1.
  - `rsp_valid`=1, `rsp_data`=0x0007, `rsp_id`=0, `rsp_err`=0 at N+2.
- REQ-024: Contention: both requesters valid from reset release (`req0` OR 0x00F0|0x000F, `req1` SUB 0x0005−0x0007), `rsp_ready`=1 → the bench SHALL check:
  - `req0` granted first: `rsp_data`=0x00FF, `rsp_id`=0.
  - Then `req1` granted 3 cycles later: `rsp_data`=0xFFFE, `rsp_id`=1.
- REQ-025: Fairness: both requesters valid continuously for 6 grants → the bench SHALL check the grant order is 0,1,0,1,0,1.
- REQ-026: Backpressure: `rsp_ready`=0 for 4 cycles in RESP → the bench SHALL check:
  - `rsp_valid`, `rsp_data` and `rsp_id` are stable.
  - Both `reqN_ready` = 0 and `busy` = 1.
  - After `rsp_ready`=1, the next grant occurs one cycle after the handshake.
- REQ-027: Illegal op: `req1` op=101 → the bench SHALL check `rsp_data`=0x0000 and `rsp_err`=1, irrespective of the `alu_s` value.
- REQ-028: Reset mid-EXEC: `rst_n`=0 asynchronously during EXEC → the bench SHALL check:
  - All outputs are 0 before the next clock edge.
  - After release, no `rsp_valid` occurs until a new grant.
